// File: rtl/deserializer.sv
// Line-fill deserializer: collects WORDS bus beats into one cache line and
// hands the line to the fill path through a valid/ready handshake.
module deserializer #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 8,
  parameter int CNT_W  = $clog2(WORDS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [WORD_W-1:0]         word_in,
  input  logic                      word_valid,
  output logic                      word_ready,
  output logic [WORD_W*WORDS-1:0]   line_out,
  output logic                      line_valid,
  input  logic                      line_ready,
  output logic [CNT_W-1:0]          beat_cnt,
  output logic                      busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_FULL
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [CNT_W-1:0]                r_beat_cnt;
  logic [WORDS-1:0][WORD_W-1:0]    r_line;
  logic                            w_accept;
  logic                            w_last;

  // A beat offered together with clear is dropped, never stored.
  assign w_accept = word_valid && word_ready && !clear;
  assign w_last   = (r_beat_cnt == CNT_W'(WORDS - 1));

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept)           w_state_nxt = S_FILL;
      S_FILL: if (w_accept && w_last) w_state_nxt = S_FULL;
      S_FULL: if (line_ready)         w_state_nxt = S_IDLE;
      default:                        w_state_nxt = S_IDLE;
    endcase
    if (clear) w_state_nxt = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Counter width equals log2(WORDS), so the increment after the last beat wraps to 0.
  always_ff @(posedge clk) begin
    if (!rst_n || clear)  r_beat_cnt <= '0;
    else if (w_accept)    r_beat_cnt <= r_beat_cnt + CNT_W'(1);
  end

  // NOTE: the line store is ordinary flops and is cleared on reset because line_out must read 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst_n)        r_line             <= '0;
    else if (w_accept) r_line[r_beat_cnt] <= word_in;
  end

  assign line_out   = r_line;
  assign beat_cnt   = r_beat_cnt;
  assign word_ready = (r_state != S_FULL);
  assign line_valid = (r_state == S_FULL);
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: table-driven line fills with a
// scoreboard queue, plus directed gap, backpressure, clear and reset sequences.
module tb_deserializer;

  localparam int WORD_W = 32;
  localparam int WORDS  = 8;
  localparam int CNT_W  = 3;
  localparam int LINE_W = WORD_W * WORDS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic [LINE_W-1:0] line_out;
  logic              line_valid;
  logic              line_ready;
  logic [CNT_W-1:0]  beat_cnt;
  logic              busy;

  int n_chk = 0;
  int n_err = 0;
  logic [LINE_W-1:0] sb[$];

  typedef struct {
    logic [LINE_W-1:0] line;
    int                gap_after;
    int                gap_len;
    int                hold;
  } vec_t;

  vec_t vecs[4];

  deserializer #(.WORD_W(WORD_W), .WORDS(WORDS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .line_out   (line_out),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .beat_cnt   (beat_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Acts as the serializer: beat k carries line[k*32 +: 32].
  task automatic send_line(input logic [LINE_W-1:0] line, input int gap_after,
                           input int gap_len);
    for (int k = 0; k < WORDS; k++) begin
      word_valid = 1'b1;
      word_in    = line[k*WORD_W +: WORD_W];
      tick();
      if (k < WORDS - 1) check("fill_cnt", beat_cnt, k + 1);
      if (k == gap_after) begin
        word_valid = 1'b0;
        word_in    = 32'hFFFF_0000;
        for (int g = 0; g < gap_len; g++) begin
          tick();
          check("gap_cnt", beat_cnt, k + 1);
        end
      end
    end
    word_valid = 1'b0;
    sb.push_back(line);
  endtask

  task automatic wait_full();
    for (int i = 0; i < 40 && !line_valid; i++) tick();
    check("line_valid_rise", line_valid, 1'b1);
  endtask

  task automatic consume(input int hold);
    logic [LINE_W-1:0] exp;
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    exp = sb.pop_front();
    check("line_out", line_out, exp);
    check("word_ready_full", word_ready, 1'b0);
    check("beat_cnt_full", beat_cnt, 0);
    for (int h = 0; h < hold; h++) tick();
    check("line_hold", line_out, exp);
    check("line_valid_hold", line_valid, 1'b1);
    line_ready = 1'b1;
    tick();
    line_ready = 1'b0;
    check("line_valid_drop", line_valid, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("word_ready_idle", word_ready, 1'b1);
  endtask

  initial begin
    logic [LINE_W-1:0] exp;

    vecs[0] = '{256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000, -1, 0, 0};
    vecs[1] = '{256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000, 2, 3, 1};
    vecs[2] = '{256'h0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF, -1, 0, 3};
    vecs[3] = '{256'hFFFFFFFF_00000000_A5A5A5A5_5A5A5A5A_80000001_7FFFFFFE_13579BDF_2468ACE0, 6, 1, 2};

    rst_n      = 1'b0;
    clear      = 1'b0;
    word_in    = '0;
    word_valid = 1'b0;
    line_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_line_valid", line_valid, 1'b0);
    check("rst_word_ready", word_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_line_out", line_out, '0);

    // Table-driven fills: basic, gapped, loopback and a mixed pattern.
    for (int v = 0; v < 4; v++) begin
      send_line(vecs[v].line, vecs[v].gap_after, vecs[v].gap_len);
      wait_full();
      consume(vecs[v].hold);
    end

    // Backpressure: offered beats in FULL must be ignored for 20 cycles.
    send_line(vecs[0].line, -1, 0);
    wait_full();
    word_valid = 1'b1;
    word_in    = 32'hDEADBEEF;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_word_ready", word_ready, 1'b0);
      check("bp_line_out", line_out, vecs[0].line);
      check("bp_beat_cnt", beat_cnt, 0);
    end
    line_ready = 1'b1;
    tick();
    line_ready = 1'b0;
    void'(sb.pop_front());
    check("bp_exit_valid", line_valid, 1'b0);
    check("bp_exit_ready", word_ready, 1'b1);
    check("bp_exit_cnt", beat_cnt, 0);
    tick();
    check("bp_first_cnt", beat_cnt, 1);
    check("bp_first_word", line_out[WORD_W-1:0], 32'hDEADBEEF);
    exp = '0;
    exp[WORD_W-1:0] = 32'hDEADBEEF;
    for (int k = 1; k < WORDS; k++) begin
      word_in = 32'h0000_1000 + 32'(k);
      exp[k*WORD_W +: WORD_W] = 32'h0000_1000 + 32'(k);
      tick();
    end
    word_valid = 1'b0;
    sb.push_back(exp);
    wait_full();
    consume(0);

    // Abort mid-burst: 5 beats, then clear together with a valid beat.
    for (int k = 0; k < 5; k++) begin
      word_valid = 1'b1;
      word_in    = 32'hA000_0000 + 32'(k);
      tick();
    end
    check("abort_pre_cnt", beat_cnt, 5);
    word_in = 32'hBAD0_BAD0;
    clear   = 1'b1;
    tick();
    clear      = 1'b0;
    word_valid = 1'b0;
    check("abort_cnt", beat_cnt, 0);
    check("abort_busy", busy, 1'b0);
    check("abort_word5_dropped", line_out[5*WORD_W +: WORD_W] == 32'hBAD0_BAD0, 1'b0);
    tick();
    check("abort_idle_hold", busy, 1'b0);
    exp = '0;
    for (int k = 0; k < WORDS; k++) exp[k*WORD_W +: WORD_W] = 32'hC000_0000 + 32'(k);
    send_line(exp, -1, 0);
    wait_full();
    consume(0);

    // Clear beats a simultaneous line handshake in FULL.
    send_line(vecs[2].line, -1, 0);
    wait_full();
    clear      = 1'b1;
    line_ready = 1'b1;
    tick();
    clear      = 1'b0;
    line_ready = 1'b0;
    void'(sb.pop_front());
    check("clear_full_valid", line_valid, 1'b0);
    check("clear_full_busy", busy, 1'b0);

    // Reset in FULL with line_ready high: nothing consumed, line zeroed.
    send_line(vecs[3].line, -1, 0);
    wait_full();
    line_ready = 1'b1;
    rst_n      = 1'b0;
    tick();
    rst_n      = 1'b1;
    line_ready = 1'b0;
    void'(sb.pop_front());
    check("rstfull_valid", line_valid, 1'b0);
    check("rstfull_line_out", line_out, '0);
    check("rstfull_cnt", beat_cnt, 0);
    tick();
    check("rstfull_stays_idle", busy, 1'b0);

    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive-side counterpart to the cache's 256-bit-to-32-bit serializer.
- Accepts a burst of WORDS consecutive 32-bit words from the memory/bus side and assembles them into one cache line.
- Presents the assembled line to the cache fill path through a valid/ready handshake.
- Sits between the main-memory read-data port and the cache line-write port; used on every line fill after a miss.

Parameters:
- WORD_W, 32, width of one bus word in bits.
- WORDS, 8, words per cache line; power of two, at least 2.
- CNT_W, $clog2(WORDS), width of the beat counter (3 at default).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low; one clock, reset is synchronous and active-low.
- clear  input  1  synchronous flush: discards any partial or completed line.
- word_in  input  WORD_W  incoming bus word.
- word_valid  input  1  word_in holds a valid beat.
- word_ready  output  1  block can accept a beat this cycle.
- line_out  output  WORD_W*WORDS  assembled line.
- line_valid  output  1  line_out holds a complete line.
- line_ready  input  1  cache consumes line_out this cycle.
- beat_cnt  output  CNT_W  number of beats accepted into the current line.
- busy  output  1  high in FILL or FULL.

Behaviour:
- Beat acceptance: a beat is accepted when word_valid && word_ready at a rising edge. A line is consumed when line_valid && line_ready at a rising edge.
- Word order: beat k (0-based) is written to line_out[k*WORD_W +: WORD_W]. The first beat lands in [31:0] and the eighth in [255:224], which matches the serializer's emission order, so serializer -> deserializer is an identity loop.
- State machine: IDLE, FILL, FULL.
  - IDLE: beat_cnt=0, word_ready=1, line_valid=0. An accepted beat stores word 0, sets beat_cnt=1 and moves to FILL.
  - FILL: word_ready=1. Each accepted beat stores at index beat_cnt and increments beat_cnt. Accepting beat index WORDS-1 moves to FULL and wraps beat_cnt to 0. Idle cycles (word_valid=0) hold all state; there is no timeout.
  - FULL: line_valid=1, word_ready=0 (backpressure), line_out stable. On line_ready, go to IDLE; line_valid drops the next cycle. With line_ready low, FULL is held indefinitely.
- Latency: line_valid rises on the clock edge that accepts the last beat, i.e. the cycle after the last word is presented. Minimum line period is WORDS+1 cycles: WORDS beats plus one FULL cycle. There is no same-cycle bypass; word_ready stays 0 throughout FULL, including the handshake cycle.
- Combinational outputs: word_ready = (state != FULL). busy = (state != IDLE). line_valid = (state == FULL). All three are registered-state decodes only, with no combinational path from inputs.
- Data register: line_out is a flop array.
  - Lanes not yet written in the current line hold their old contents; no zeroing is required.
  - When line_valid=1, all lanes must be from the current burst.
- clear:
  - In any state, returns to IDLE with beat_cnt=0 and line_valid=0 on the next edge.
  - A beat offered in the same cycle as clear is dropped.
  - clear overrides a simultaneous line handshake; the line counts as discarded.
- Reset: rst_n=0 at an edge forces IDLE, beat_cnt=0, line_valid=0 and line_out=0. It has the same priority as clear and above it; mid-burst reset discards the partial line.
- Width rules:
  - beat_cnt wraps modulo WORDS; it never exceeds WORDS-1.
  - Beat acceptance cannot occur in FULL, so overflow is impossible by construction.
- X-safety: word_in is not sampled when word_valid=0. line_ready is ignored outside FULL.

Test Plan:
- Basic fill: after reset, drive 8 back-to-back beats 0x00000000..0x00000007 with line_ready=0 -> line_valid rises the cycle after the 8th beat; line_out = 0x00000007_00000006_..._00000000; word_ready=0. Then assert line_ready one cycle -> IDLE, busy=0.
- Gapped input: same 8 words with word_valid low for 3 cycles between beats 2 and 3 -> identical line_out; beat_cnt holds at 3 during the gap.
- Backpressure: hold line_ready=0 for 20 cycles in FULL while word_valid=1 with word_in=0xDEADBEEF -> word_ready=0, line_out unchanged, no beat accepted. Release -> the next line starts with 0xDEADBEEF at [31:0] one cycle after FULL exits.
- Loopback: feed the serializer with 0x0123...CDEF (256-bit) into the deserializer -> line_out equals the input bit-exact.
- Abort mid-burst: accept 5 beats, then pulse clear together with word_valid -> beat_cnt=0, IDLE; the next 8 beats form a clean line; no stale word appears in any lane.
- Reset mid-operation: drive rst_n=0 in FULL with line_ready=1 -> no consumption credited; line_valid=0, line_out=0, beat_cnt=0 after the edge.
